// File: rtl/versat_cfg_pkg.sv
// Shared types and constants for the Versat configuration loader.
package versat_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_H   = 3'd1,
    ST_FETCH_D   = 3'd2,
    ST_WRITE     = 3'd3,
    ST_RUN       = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_FINISH    = 3'd6
  } state_e;

  // Header word layout: unit address in the low bits, byte strobes from bit 16.
  localparam int HDR_STRB_LSB = 16;
  // Each table entry occupies a header word followed by a data word.
  localparam int ENTRY_STRIDE = 2;

endpackage

// File: rtl/versat_config_loader.sv
// Walks a table of (address, strobe, data) entries, replays them as unit bus
// writes, then optionally launches the accelerator and waits for completion.
module versat_config_loader
  import versat_cfg_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int TBL_ADDR_W = 10,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TBL_ADDR_W-1:0] tbl_base,
  input  logic [CNT_W-1:0]      count,
  input  logic                  auto_run,
  output logic                  busy,
  output logic                  cmd_done,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      entries_done,
  output logic                  tbl_valid,
  output logic [TBL_ADDR_W-1:0] tbl_addr,
  input  logic                  tbl_ready,
  input  logic [DATA_W-1:0]     tbl_rdata,
  output logic                  valid,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     wdata,
  input  logic                  ready,
  output logic                  run,
  input  logic                  done
);

  localparam int STRB_W = DATA_W / 8;
  // Timeout fires on the cycle the counter would step onto its all-ones value.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e                state_q, state_d;
  logic [TBL_ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic                  auto_run_q, auto_run_d;
  logic [ADDR_W-1:0]     hdr_addr_q, hdr_addr_d;
  logic [STRB_W-1:0]     hdr_strb_q, hdr_strb_d;
  logic [TIMEOUT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]      entries_done_q, entries_done_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [TBL_ADDR_W-1:0] tbl_addr_q, tbl_addr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  busy_q, tbl_valid_q, valid_q, run_q, cmd_done_q;
  logic                  entry_end_s;
  logic [TBL_ADDR_W-1:0] next_base_s;

  assign next_base_s = base_q + TBL_ADDR_W'(ENTRY_STRIDE);

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    rem_d          = rem_q;
    auto_run_d     = auto_run_q;
    hdr_addr_d     = hdr_addr_q;
    hdr_strb_d     = hdr_strb_q;
    to_cnt_d       = to_cnt_q;
    entries_done_d = entries_done_q;
    timeout_err_d  = timeout_err_q;
    tbl_addr_d     = tbl_addr_q;
    addr_d         = addr_q;
    wstrb_d        = wstrb_q;
    wdata_d        = wdata_q;
    entry_end_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d         = tbl_base;
          rem_d          = count;
          auto_run_d     = auto_run;
          entries_done_d = '0;
          timeout_err_d  = 1'b0;
          tbl_addr_d     = tbl_base;
          if (count != '0) begin
            state_d = ST_FETCH_H;
          end else if (auto_run) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FINISH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH_H: begin
        if (tbl_ready) begin
          hdr_addr_d = tbl_rdata[ADDR_W-1:0];
          hdr_strb_d = tbl_rdata[HDR_STRB_LSB +: STRB_W];
          tbl_addr_d = base_q + TBL_ADDR_W'(1);
          state_d    = ST_FETCH_D;
        end else begin
          state_d = ST_FETCH_H;
        end
      end
      ST_FETCH_D: begin
        if (tbl_ready) begin
          // An all-zero strobe means the entry carries no write; skip the bus.
          if (hdr_strb_q == '0) begin
            entry_end_s = 1'b1;
          end else begin
            addr_d  = hdr_addr_q;
            wstrb_d = hdr_strb_q;
            wdata_d = tbl_rdata;
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_FETCH_D;
        end
      end
      ST_WRITE: begin
        if (ready) begin
          entry_end_s = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_RUN: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // done is stale on the first cycle after run, hence the nonzero gate.
        if ((to_cnt_q != '0) && done) begin
          state_d = ST_FINISH;
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d      = '1;
          timeout_err_d = 1'b1;
          state_d       = ST_FINISH;
        end else begin
          to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (entry_end_s) begin
      entries_done_d = entries_done_q + CNT_W'(1);
      rem_d          = rem_q - CNT_W'(1);
      base_d         = next_base_s;
      tbl_addr_d     = next_base_s;
      if (rem_q != CNT_W'(1)) begin
        state_d = ST_FETCH_H;
      end else if (auto_run_q) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_FINISH;
      end
    end else begin
      rem_d = rem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      rem_q          <= '0;
      auto_run_q     <= 1'b0;
      hdr_addr_q     <= '0;
      hdr_strb_q     <= '0;
      to_cnt_q       <= '0;
      entries_done_q <= '0;
      timeout_err_q  <= 1'b0;
      tbl_addr_q     <= '0;
      addr_q         <= '0;
      wstrb_q        <= '0;
      wdata_q        <= '0;
      busy_q         <= 1'b0;
      tbl_valid_q    <= 1'b0;
      valid_q        <= 1'b0;
      run_q          <= 1'b0;
      cmd_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      rem_q          <= rem_d;
      auto_run_q     <= auto_run_d;
      hdr_addr_q     <= hdr_addr_d;
      hdr_strb_q     <= hdr_strb_d;
      to_cnt_q       <= to_cnt_d;
      entries_done_q <= entries_done_d;
      timeout_err_q  <= timeout_err_d;
      tbl_addr_q     <= tbl_addr_d;
      addr_q         <= addr_d;
      wstrb_q        <= wstrb_d;
      wdata_q        <= wdata_d;
      // Request/status flags are registered from the next state, so they
      // align with the state they describe and never see ready/done directly.
      busy_q         <= (state_d != ST_IDLE);
      tbl_valid_q    <= (state_d == ST_FETCH_H) || (state_d == ST_FETCH_D);
      valid_q        <= (state_d == ST_WRITE);
      run_q          <= (state_d == ST_RUN);
      cmd_done_q     <= (state_d == ST_FINISH);
    end
  end

  assign busy         = busy_q;
  assign cmd_done     = cmd_done_q;
  assign timeout_err  = timeout_err_q;
  assign entries_done = entries_done_q;
  assign tbl_valid    = tbl_valid_q;
  assign tbl_addr     = tbl_addr_q;
  assign valid        = valid_q;
  assign addr         = addr_q;
  assign wstrb        = wstrb_q;
  assign wdata        = wdata_q;
  assign run          = run_q;

endmodule

// File: tb/tb_versat_config_loader.sv
// Directed bench for versat_config_loader: a transaction-level model predicts
// reads, writes, run pulses and command length; a negedge process compares.
module tb_versat_config_loader;

  typedef struct packed {
    logic [4:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  tbl_base = 10'd0;
  logic [7:0]  count = 8'd0;
  logic        auto_run = 1'b0;
  logic        busy, cmd_done, timeout_err, tbl_valid, valid, run;
  logic [7:0]  entries_done;
  logic [9:0]  tbl_addr;
  logic [4:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        tbl_ready = 1'b0;
  logic [31:0] tbl_rdata = 32'd0;
  logic        ready = 1'b0;
  logic        done = 1'b0;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  // Stimulus knobs and model expectations
  int tbl_lat = 0, bus_lat = 0, done_delay = -1;
  int exp_len = 0, exp_entries = 0, exp_runs = 0, exp_tmo = 0;
  wr_t exp_wr[$];
  int  exp_rd[$];
  wr_t wlog[$];
  int  rlog[$];

  // Monitor state
  bit active = 1'b0, abort = 1'b0, darm = 1'b0, prev_ready = 1'b0;
  int cyc = 0, done_cyc = -1, runs_seen = 0, tw = 0, bw = 0, dcnt = 0;
  logic [9:0] held_ta = 10'd0;
  wr_t held_wr = '0;

  versat_config_loader #(
    .ADDR_W(5), .DATA_W(32), .TBL_ADDR_W(10), .CNT_W(8), .TIMEOUT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_base(tbl_base), .count(count),
    .auto_run(auto_run), .busy(busy), .cmd_done(cmd_done),
    .timeout_err(timeout_err), .entries_done(entries_done),
    .tbl_valid(tbl_valid), .tbl_addr(tbl_addr), .tbl_ready(tbl_ready),
    .tbl_rdata(tbl_rdata), .valid(valid), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .ready(ready), .run(run), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Responders, done generator and per-cycle comparison against the model.
  always @(negedge clk) begin
    wr_t obs;
    tbl_ready = 1'b0;
    if (tbl_valid === 1'b1) begin
      if (tw > 0) chk("tbl_addr_stable", tbl_addr, held_ta);
      held_ta = tbl_addr;
      if (tw >= tbl_lat) begin
        tbl_ready = 1'b1;
        tbl_rdata = mem[tbl_addr];
        rlog.push_back(int'(tbl_addr));
        if (active) begin
          if (exp_rd.size() == 0) chk("tbl_rd_extra", {54'd0, tbl_addr}, 64'hFFFF);
          else chk("tbl_rd_addr", {54'd0, tbl_addr}, exp_rd.pop_front());
        end
        tw = 0;
      end else begin
        tw++;
      end
    end else begin
      tw = 0;
    end

    if (prev_ready) chk("valid_gap", valid, 1'b0);
    ready = 1'b0;
    if (valid === 1'b1) begin
      obs = {addr, wstrb, wdata};
      if (bw > 0) chk("bus_stable", obs, held_wr);
      held_wr = obs;
      if (bw >= bus_lat) begin
        ready = 1'b1;
        wlog.push_back(obs);
        if (active) begin
          if (exp_wr.size() == 0) chk("bus_wr_extra", obs, 64'hFFFF_FFFF_FFFF);
          else chk("bus_wr", obs, exp_wr.pop_front());
        end
        bw = 0;
      end else begin
        bw++;
      end
    end else begin
      bw = 0;
    end
    prev_ready = ready;
    if (tbl_valid === 1'b1 && valid === 1'b1) chk("req_exclusive", 1'b1, 1'b0);

    if (run === 1'b1) begin
      runs_seen++;
      darm = 1'b1;
      dcnt = 0;
    end else if (darm) begin
      dcnt++;
    end
    done = darm && (done_delay >= 0) && (dcnt >= done_delay);

    if (abort) active = 1'b0;
    if (start && busy === 1'b0 && !rst && !abort) begin
      active = 1'b1;
      cyc = 0;
    end else begin
      cyc++;
    end
    if (active) begin
      chk("busy", busy, (cyc >= 1 && cyc <= exp_len));
      chk("cmd_done", cmd_done, (cyc == exp_len));
      if (cmd_done === 1'b1) done_cyc = cyc;
      if (cyc == exp_len) begin
        chk("entries_done", entries_done, exp_entries);
        chk("timeout_err", timeout_err, exp_tmo);
        chk("reads_left", exp_rd.size(), 0);
        chk("writes_left", exp_wr.size(), 0);
        chk("run_pulses", runs_seen, exp_runs);
        darm = 1'b0;
        done = 1'b0;
      end
      if (cyc > exp_len) active = 1'b0;
    end
  end

  // Build the expected transaction lists and command length, then launch.
  task automatic run_cmd(input int base, input int cnt, input bit ar);
    int len, ha, da, kd;
    logic [31:0] h;
    @(posedge clk);
    #1;
    exp_wr.delete(); exp_rd.delete(); wlog.delete(); rlog.delete();
    len = 1;
    exp_tmo = 0;
    for (int i = 0; i < cnt; i++) begin
      ha = (base + 2 * i) % 1024;
      da = (ha + 1) % 1024;
      exp_rd.push_back(ha);
      exp_rd.push_back(da);
      h = mem[ha];
      len += 2 * (tbl_lat + 1);
      if (h[19:16] != 4'd0) begin
        exp_wr.push_back({h[4:0], h[19:16], mem[da]});
        len += bus_lat + 1;
      end
    end
    if (ar) begin
      kd = done_delay - 1;
      if (done_delay < 0 || kd > 14) begin
        len += 1 + 15;
        exp_tmo = 1;
      end else begin
        len += 1 + ((kd <= 0) ? 2 : kd + 1);
      end
    end
    exp_len = len;
    exp_entries = cnt;
    exp_runs = ar ? 1 : 0;
    runs_seen = 0;
    done_cyc = -1;
    darm = 1'b0;
    done = 1'b0;
    abort = 1'b0;
    tbl_base = base[9:0];
    count = cnt[7:0];
    auto_run = ar;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    auto_run = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 300 && active; i++) @(posedge clk);
    if (active) begin
      chk({nm, "_timeout"}, 1'b1, 1'b0);
      active = 1'b0;
    end
    #1;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_cmd_done"}, cmd_done, 1'b0);
    chk({nm, "_timeout_err"}, timeout_err, 1'b0);
    chk({nm, "_reqs"}, {tbl_valid, valid, run}, 3'b000);
    chk({nm, "_entries"}, entries_done, 8'd0);
    chk({nm, "_tbl_addr"}, tbl_addr, 10'd0);
    chk({nm, "_bus"}, {addr, wstrb, wdata}, 41'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0]    = 32'h0001_0003;
    mem[1]    = 32'hDEAD_BEEF;
    mem[2]    = 32'h000F_0012;
    mem[3]    = 32'h1234_5678;
    mem[8]    = 32'h0000_0007;
    mem[9]    = 32'hFFFF_FFFF;
    mem[10]   = 32'h0003_0009;
    mem[11]   = 32'hCAFE_F00D;
    mem[1023] = 32'h000C_0015;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Zero-wait, two written entries
    tbl_lat = 0; bus_lat = 0;
    run_cmd(0, 2, 1'b0);
    wait_idle("t1");
    chk("t1_len", done_cyc, 7);
    chk("t1_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t1_wr0", wlog[0], {5'h03, 4'h1, 32'hDEAD_BEEF});
      chk("t1_wr1", wlog[1], {5'h12, 4'hF, 32'h1234_5678});
    end
    chk("t1_entries", entries_done, 8'd2);

    // Slow table and bus; a start while busy must be ignored
    tbl_lat = 2; bus_lat = 4;
    run_cmd(0, 2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; tbl_base = 10'd200; count = 8'd5; auto_run = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; auto_run = 1'b0;
    wait_idle("t2");
    chk("t2_len", done_cyc, 23);
    chk("t2_nwr", wlog.size(), 2);

    // Zero strobe on first entry skips its bus write
    tbl_lat = 0; bus_lat = 0;
    run_cmd(8, 2, 1'b0);
    wait_idle("t3");
    chk("t3_len", done_cyc, 6);
    chk("t3_nwr", wlog.size(), 1);
    if (wlog.size() == 1) chk("t3_wr0", wlog[0], {5'h09, 4'h3, 32'hCAFE_F00D});
    chk("t3_entries", entries_done, 8'd2);

    // Run only, done arrives 10 cycles after run
    done_delay = 10;
    run_cmd(0, 0, 1'b1);
    wait_idle("t4a");
    chk("t4a_len", done_cyc, 12);
    chk("t4a_runs", runs_seen, 1);
    chk("t4a_tmo", timeout_err, 1'b0);

    // done never comes: timeout
    done_delay = -1;
    run_cmd(0, 0, 1'b1);
    wait_idle("t4b");
    chk("t4b_len", done_cyc, 17);
    repeat (3) @(negedge clk);
    chk("t4b_tmo_sticky", timeout_err, 1'b1);

    // Table address wrap-around; also clears the sticky timeout
    run_cmd(1023, 1, 1'b0);
    wait_idle("t5");
    chk("t5_nrd", rlog.size(), 2);
    if (rlog.size() == 2) begin
      chk("t5_rd0", rlog[0], 1023);
      chk("t5_rd1", rlog[1], 0);
    end
    if (wlog.size() == 1) chk("t5_wr0", wlog[0], {5'h15, 4'hC, 32'h0001_0003});
    else chk("t5_nwr", wlog.size(), 1);
    chk("t5_tmo_cleared", timeout_err, 1'b0);

    // Reset during a stalled write, together with a busy-time start
    bus_lat = 20;
    run_cmd(0, 2, 1'b0);
    for (int i = 0; i < 20 && valid !== 1'b1; i++) @(negedge clk);
    chk("t6_valid_seen", valid, 1'b1);
    @(posedge clk);
    #1;
    abort = 1'b1; rst = 1'b1; start = 1'b1; tbl_base = 10'd100; count = 8'd1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset_vals("t6_rst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_cmd_done", cmd_done, 1'b0);
      chk("t6_stays_idle", busy, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
